// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: word type, FSM state enum and
// the data word returned when the RAM watchdog aborts an access.
package mem_responder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DACC   = 3'd1,
        IACC   = 3'd2,
        RESP   = 3'd3,
        HALTED = 3'd4
    } resp_state_t;

    localparam word_t ERR_WORD = 32'hBAD0BAD0;

endpackage

// File: rtl/mem_responder_if.sv
// Datapath-to-memory request bus plus the backing RAM handshake.
//
// Handshake: a requester raises imemREN / dmemREN / dmemWEN and holds it,
// with address and store data stable, until the matching ihit / dhit
// pulse (one cycle, load data valid in that cycle). On the RAM side the
// responder holds ramREN / ramWEN, ramaddr and ramstore stable until the
// cycle ramready is high; ramload is sampled in that cycle.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    word_t imemload;
    logic  ihit;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    word_t dmemload;
    logic  dhit;
    logic  halt;
    logic  flushed;
    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;
    word_t ramload;
    logic  ramready;
    logic  err;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
               halt, ramload, ramready,
        output imemload, ihit, dmemload, dhit, flushed,
               ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
               halt, ramload, ramready,
        input  imemload, ihit, dmemload, dhit, flushed,
               ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/mem_responder_ifetch_buffer.sv
// One-entry instruction buffer: valid bit, address tag and data word.
// Filled after a completed fetch, invalidated by a store to the tag.
module ifetch_buffer
    import mem_responder_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  word_t lookup_addr,
    output logic  lookup_hit,
    output word_t lookup_data,
    input  logic  fill_en,
    input  word_t fill_addr,
    input  word_t fill_data,
    input  logic  inv_en,
    input  word_t inv_addr
);

    logic  valid_q;
    word_t tag_q;
    word_t data_q;

    // Entry update: fill takes priority, invalidate only on tag match.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
            tag_q   <= fill_addr;
            data_q  <= fill_data;
        end else if (inv_en && (inv_addr == tag_q)) begin
            valid_q <= 1'b0;
        end
    end

    assign lookup_hit  = valid_q && (tag_q == lookup_addr);
    assign lookup_data = data_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: serves instruction fetches and data loads/stores from
// a single-ported RAM, data first, with a per-access watchdog and a
// terminal halt/flush state. Optional one-entry fetch buffer is enabled
// by defining IPREFETCH_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic           CLK,
    input  logic           RST,
    mem_responder_if.slave bus,
    output resp_state_t    state_dbg
);

    resp_state_t state;
    resp_state_t next_state;

    word_t       addr_q;
    word_t       store_q;
    word_t       resp_q;
    logic        is_d_q;
    logic        is_wr_q;
    logic        err_q;
    logic [7:0]  wait_q;

    logic        dreq;
    logic        ireq_ok;
    logic        timeout;
    logic        pf_hit;
    word_t       pf_data;

    assign dreq    = bus.dmemREN | bus.dmemWEN;
    assign ireq_ok = bus.imemREN & ~bus.halt;
    assign timeout = (wait_q == 8'(MAX_WAIT));

`ifdef IPREFETCH_EN
    logic fill_en;
    logic inv_en;

    assign fill_en = (state == IACC) && bus.ramready;
    assign inv_en  = (state == RESP) && is_d_q && is_wr_q;

    ifetch_buffer u_ibuf (
        .clk         (CLK),
        .rst         (RST),
        .lookup_addr (bus.imemaddr),
        .lookup_hit  (pf_hit),
        .lookup_data (pf_data),
        .fill_en     (fill_en),
        .fill_addr   (addr_q),
        .fill_data   (bus.ramload),
        .inv_en      (inv_en),
        .inv_addr    (addr_q)
    );
`else
    assign pf_hit  = 1'b0;
    assign pf_data = '0;
`endif

    // State register; reset abandons any access in flight.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state: data beats fetch, halt blocks new fetches only.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dreq)         next_state = DACC;
                else if (ireq_ok) next_state = pf_hit ? RESP : IACC;
                else if (bus.halt) next_state = HALTED;
            end
            DACC, IACC: begin
                if (bus.ramready || timeout) next_state = RESP;
            end
            RESP:    next_state = IDLE;
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    // Request latch, response capture and watchdog counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= '0;
            store_q <= '0;
            resp_q  <= '0;
            is_d_q  <= 1'b0;
            is_wr_q <= 1'b0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq) begin
                        addr_q  <= bus.dmemaddr;
                        store_q <= bus.dmemstore;
                        is_d_q  <= 1'b1;
                        is_wr_q <= bus.dmemWEN;
                        wait_q  <= '0;
                    end else if (ireq_ok) begin
                        addr_q  <= bus.imemaddr;
                        store_q <= '0;
                        is_d_q  <= 1'b0;
                        is_wr_q <= 1'b0;
                        wait_q  <= '0;
                        if (pf_hit) resp_q <= pf_data;
                    end
                end
                DACC, IACC: begin
                    // A store returns 0; the RAM read data is meaningless.
                    if (bus.ramready) begin
                        resp_q <= (is_d_q && is_wr_q) ? '0 : bus.ramload;
                    end else if (timeout) begin
                        resp_q <= ERR_WORD;
                        err_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from the registered state and latched request.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ihit     = 1'b0;
        bus.dhit     = 1'b0;
        bus.imemload = '0;
        bus.dmemload = '0;
        bus.flushed  = 1'b0;
        case (state)
            DACC: begin
                bus.ramREN   = ~is_wr_q;
                bus.ramWEN   = is_wr_q;
                bus.ramaddr  = addr_q;
                bus.ramstore = store_q;
            end
            IACC: begin
                bus.ramREN   = 1'b1;
                bus.ramaddr  = addr_q;
                bus.ramstore = store_q;
            end
            RESP: begin
                bus.ihit     = ~is_d_q;
                bus.dhit     = is_d_q;
                bus.imemload = is_d_q ? '0 : resp_q;
                bus.dmemload = is_d_q ? resp_q : '0;
            end
            IDLE: begin
                // Flushed as soon as the idle block commits to halting.
                bus.flushed = bus.halt & ~dreq;
            end
            HALTED: begin
                bus.flushed = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.err   = err_q;
    assign state_dbg = state;

endmodule
